// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM built-in self-test controller:
// FSM state encoding, pattern-select codes and the expected-data generator.
package ram_bist_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

  localparam logic [1:0] PAT_DBL  = 2'd0;
  localparam logic [1:0] PAT_CHK  = 2'd1;
  localparam logic [1:0] PAT_ONES = 2'd2;
  localparam logic [1:0] PAT_ADDR = 2'd3;

  // Computed at the widest supported data width; callers truncate to DATA_W.
  function automatic logic [15:0] expected(input logic [15:0] addr,
                                           input logic [1:0]  pattern,
                                           input int          data_w);
    logic [15:0] dbl;
    logic [15:0] res;
    int          h;
    dbl = addr << 1;
    res = '0;
    h   = data_w / 2;
    for (int i = 0; i < 16; i++) begin
      if (i < data_w) begin
        case (pattern)
          PAT_DBL:  res[i] = dbl[i];
          PAT_CHK:  res[i] = (i % 2 == 0) ? ~addr[0] : addr[0];
          PAT_ONES: res[i] = 1'b1;
          default:  res[i] = (i < h) ? ~addr[i] : addr[i-h];
        endcase
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker: aligns expected data/address with the RAM read latency,
// then counts mismatching locations and remembers the first failing address.
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rd_vld,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_exp,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W:0]   fail_count
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign cmp_vld  = rd_vld;
      assign cmp_addr = rd_addr;
      assign cmp_exp  = rd_exp;
    end else begin : g_lat1
      logic              dly_vld_q;
      logic [ADDR_W-1:0] dly_addr_q;
      logic [DATA_W-1:0] dly_exp_q;
      // NOTE: only the valid bit needs reset; addr/exp are ignored while it is low.
      always_ff @(posedge clk) begin
        if (rst) dly_vld_q <= 1'b0;
        else     dly_vld_q <= rd_vld;
        dly_addr_q <= rd_addr;
        dly_exp_q  <= rd_exp;
      end
      assign cmp_vld  = dly_vld_q;
      assign cmp_addr = dly_addr_q;
      assign cmp_exp  = dly_exp_q;
    end
  endgenerate

  logic              mism;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [ADDR_W:0]   fail_count_q, fail_count_d;

  assign mism = cmp_vld && (ram_data_out != cmp_exp);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fail_addr_d  = fail_addr_q;
    fail_count_d = fail_count_q;
    if (clear) begin
      fail_addr_d  = '0;
      fail_count_d = '0;
    end else if (mism) begin
      if (fail_count_q == '0)    fail_addr_d  = cmp_addr;
      if (fail_count_q != DEPTH) fail_count_d = fail_count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else begin
      fail_addr_q  <= fail_addr_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign fail_addr  = fail_addr_q;
  assign fail_count = fail_count_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// BIST controller in front of a single-port RAM: writes a selected pattern to
// every location, reads it all back and reports pass/fail through ram_bist_cmp.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W:0]   fail_count,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2**ADDR_W - 1);

  state_e            state_q, state_d;
  logic              launch_q, launch_d;
  logic [1:0]        pat_q, pat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [1:0]        drain_q, drain_d;

  logic              accept;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] exp_first, exp_next, exp_cur;

  // launch_q marks the one cycle between an accepted start and the first write.
  assign accept    = start && !launch_q && (state_q == IDLE || state_q == DONE);
  assign addr_inc  = addr_q + 1'b1;
  assign exp_first = DATA_W'(expected(16'd0, pat_q, DATA_W));
  assign exp_next  = DATA_W'(expected(16'(addr_inc), pat_q, DATA_W));
  assign exp_cur   = DATA_W'(expected(16'(addr_q), pat_q, DATA_W));

  always_comb begin
    state_d  = state_q;
    launch_d = accept;
    pat_d    = accept ? pattern_sel : pat_q;
    addr_d   = addr_q;
    wr_en_d  = 1'b0;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = accept ? 1'b0 : done_q;
    pass_d   = accept ? 1'b0 : pass_q;
    drain_d  = drain_q;
    if (launch_q) begin
      state_d = WRITE;
      addr_d  = '0;
      wr_en_d = 1'b1;
      data_d  = exp_first;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        WRITE: begin
          if (addr_q == LAST_ADDR) begin
            state_d = READ;
            addr_d  = '0;
          end else begin
            addr_d  = addr_inc;
            wr_en_d = 1'b1;
            data_d  = exp_next;
          end
        end
        READ: begin
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            addr_d = addr_inc;
          end
        end
        DRAIN: begin
          if (drain_q == 2'(RD_LAT)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_count == '0);
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      launch_q <= 1'b0;
      pat_q    <= '0;
      addr_q   <= '0;
      wr_en_q  <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      pat_q    <= pat_d;
      addr_q   <= addr_d;
      wr_en_q  <= wr_en_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      drain_q  <= drain_d;
    end
  end

  ram_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept),
    .rd_vld       (state_q == READ),
    .rd_addr      (addr_q),
    .rd_exp       (exp_cur),
    .ram_data_out (ram_data_out),
    .fail_addr    (fail_addr),
    .fail_count   (fail_count)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_addr    = addr_q;
  assign ram_data_in = data_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl with a 16x8 RAM model (1-cycle read)
// whose read data can be corrupted per address.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] pattern_sel;
  logic       busy, done, pass;
  logic [3:0] fail_addr;
  logic [4:0] fail_count;
  logic       ram_wr_en;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;

  always #5 clk = ~clk;

  ram_bist_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pattern_sel  (pattern_sel),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr),
    .fail_count   (fail_count),
    .ram_wr_en    (ram_wr_en),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // RAM model with read-data fault injection keyed on the read address.
  logic [7:0]  mem [16];
  logic [7:0]  rd_q;
  logic [3:0]  rd_addr_q;
  logic [15:0] fault_map = '0;
  logic [7:0]  fault_xor = '0;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_data_in;
    rd_q      <= mem[ram_addr];
    rd_addr_q <= ram_addr;
  end
  assign ram_data_out = fault_map[rd_addr_q] ? (rd_q ^ fault_xor) : rd_q;

  int checks = 0;
  int errors = 0;
  logic [7:0] wr7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_exp(input int a, input logic [1:0] p);
    logic [3:0] a4;
    a4 = a[3:0];
    case (p)
      2'd0:    return 8'(a * 2);
      2'd1:    return a4[0] ? 8'hAA : 8'h55;
      2'd2:    return 8'hFF;
      default: return {a4, ~a4};
    endcase
  endfunction

  // One full run: start accepted at edge 0, results checked at edge 35.
  // mid_start > 0 pulses start (with a different pattern) at that edge.
  task automatic run(input string name, input logic [1:0] pat, input logic [15:0] fmap,
                     input logic [7:0] fx, input int mid_start, input logic exp_pass,
                     input logic [4:0] exp_cnt, input logic [3:0] exp_addr);
    int wr_cycles;
    wr_cycles = 0;
    fault_map = fmap;
    fault_xor = fx;
    @(negedge clk);
    start       = 1'b1;
    pattern_sel = pat;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    pattern_sel = ~pat;
    check({name, " cleared done"}, 32'(done), 32'd0);
    check({name, " cleared count"}, 32'(fail_count), 32'd0);
    for (int e = 1; e <= 35; e++) begin
      if (e == mid_start) begin
        start       = 1'b1;
        pattern_sel = ~pat;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (ram_wr_en) wr_cycles++;
      if (e <= 16) begin
        check($sformatf("%s wr_en e%0d", name, e), 32'(ram_wr_en), 32'd1);
        check($sformatf("%s addr e%0d", name, e), 32'(ram_addr), 32'(e - 1));
        check($sformatf("%s wdata e%0d", name, e), 32'(ram_data_in), 32'(tb_exp(e - 1, pat)));
        if (e == 8) wr7 = ram_data_in;
      end
      if (e == 1)  check({name, " busy rise"}, 32'(busy), 32'd1);
      if (e == 17) begin
        check({name, " first read wr_en"}, 32'(ram_wr_en), 32'd0);
        check({name, " first read addr"}, 32'(ram_addr), 32'd0);
      end
      if (e == 34) begin
        check({name, " busy e34"}, 32'(busy), 32'd1);
        check({name, " done e34"}, 32'(done), 32'd0);
        check({name, " drain addr"}, 32'(ram_addr), 32'd15);
      end
    end
    start = 1'b0;
    check({name, " done e35"}, 32'(done), 32'd1);
    check({name, " busy e35"}, 32'(busy), 32'd0);
    check({name, " pass"}, 32'(pass), 32'(exp_pass));
    check({name, " fail_count"}, 32'(fail_count), 32'(exp_cnt));
    check({name, " fail_addr"}, 32'(fail_addr), 32'(exp_addr));
    check({name, " write cycles"}, 32'(wr_cycles), 32'd16);
  endtask

  typedef struct {
    logic [1:0]  pat;
    logic [15:0] fmap;
    logic [7:0]  fx;
    logic        exp_pass;
    logic [4:0]  exp_cnt;
    logic [3:0]  exp_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bad_idle;
    vecs[0] = '{2'd0, 16'h0000, 8'h00, 1'b1, 5'd0,  4'd0};
    vecs[1] = '{2'd1, 16'h0020, 8'h01, 1'b0, 5'd1,  4'd5};
    vecs[2] = '{2'd2, 16'h1008, 8'hFF, 1'b0, 5'd2,  4'd3};
    vecs[3] = '{2'd3, 16'h0000, 8'h00, 1'b1, 5'd0,  4'd0};
    vecs[4] = '{2'd0, 16'h8000, 8'h80, 1'b0, 5'd1,  4'd15};
    vecs[5] = '{2'd1, 16'hFFFF, 8'h01, 1'b0, 5'd16, 4'd0};

    // Reset and idle.
    rst = 1'b1; start = 1'b0; pattern_sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst pass", 32'(pass), 32'd0);
    check("rst fail_addr", 32'(fail_addr), 32'd0);
    check("rst fail_count", 32'(fail_count), 32'd0);
    check("rst wr_en", 32'(ram_wr_en), 32'd0);
    check("rst addr", 32'(ram_addr), 32'd0);
    check("rst data_in", 32'(ram_data_in), 32'd0);
    rst = 1'b0;
    bad_idle = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ram_wr_en || busy || done || pass || fail_count != 0) bad_idle++;
    end
    check("idle quiet cycles", 32'(bad_idle), 32'd0);

    // Table-driven runs.
    for (int i = 0; i < 6; i++)
      run($sformatf("vec%0d", i), vecs[i].pat, vecs[i].fmap, vecs[i].fx, -1,
          vecs[i].exp_pass, vecs[i].exp_cnt, vecs[i].exp_addr);

    // Start during busy is ignored; relaunch clears the failing results.
    run("midstart", 2'd0, 16'h0020, 8'h01, 10, 1'b0, 5'd1, 4'd5);
    run("relaunch", 2'd3, 16'h0000, 8'h00, -1, 1'b1, 5'd0, 4'd0);
    check("relaunch addr7 data", 32'(wr7), 32'h78);

    // Reset in the middle of the write phase.
    @(negedge clk);
    start = 1'b1; pattern_sel = 2'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre-rst wr_en", 32'(ram_wr_en), 32'd1);
    check("pre-rst addr", 32'(ram_addr), 32'd6);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst wr_en e8", 32'(ram_wr_en), 32'd0);
    check("midrst busy e8", 32'(busy), 32'd0);
    check("midrst done e8", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst wr_en e9", 32'(ram_wr_en), 32'd0);
    check("midrst busy e9", 32'(busy), 32'd0);
    check("midrst done e9", 32'(done), 32'd0);
    run("after_rst", 2'd2, 16'h0000, 8'h00, -1, 1'b1, 5'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
